ms_jk_bank: RTL
===============

MS_JK_BANK -- requirements
Module: ms_jk_bank

Interface
REQ-001 Parameter WIDTH, default 8, number of independent master-slave flip-flop bits (1..64).
REQ-002 Parameter INIT, default {WIDTH{1'b0}}, value loaded into master and slave on reset.
REQ-003 clk  input  1  single clock; master stage samples on rising edge, slave stage on falling edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 mode  input  2  operating mode, common to all bits: 00 JK, 01 D, 10 T, 11 SR.
REQ-006 en  input  WIDTH  per-bit enable; en[i]=0 holds bit i.
REQ-007 j  input  WIDTH  J / D / T / S input per bit, interpreted according to mode.
REQ-008 k  input  WIDTH  K / R input per bit; ignored in D and T modes.
REQ-009 q  output  WIDTH  slave-stage output, registered.
REQ-010 qn  output  WIDTH  bitwise complement of q, always equal to ~q.
REQ-011 err  output  1  sticky SR-violation flag; present only when MS_JK_ERR_EN is defined (REQ-031).

Function
REQ-012 Each bit shall contain a master register and a slave register; q[i] is the slave register.
REQ-013 On each rising clk edge, master[i] shall be computed from current q[i], j[i], k[i], en[i] and mode.
REQ-014 On each falling clk edge, q[i] shall take master[i]; no other path shall update q.
REQ-015 Latency: inputs sampled at rising edge N appear on q at the falling edge of the same cycle; q is stable for the whole high phase.
REQ-016 en[i]=0: master[i] <= q[i] at the rising edge, independent of mode, j and k.
REQ-017 JK mode, en[i]=1: jk=00 hold (q), 01 clear (0), 10 set (1), 11 toggle (~q).
REQ-018 D mode, en[i]=1: master[i] <= j[i].
REQ-019 T mode, en[i]=1: master[i] <= q[i] ^ j[i].
REQ-020 SR mode, en[i]=1: jk=00 hold, 10 set, 01 clear, 11 illegal -> hold (master[i] <= q[i]).
REQ-021 Toggle in JK/T mode shall flip q exactly once per clock cycle; there shall be no race-through within one cycle.
REQ-022 A mode change takes effect at the next rising edge; a master value already captured shall transfer to q unchanged at the following falling edge.
REQ-023 Bits shall be fully independent; bit i behaviour shall not depend on j, k or en of any other bit.
REQ-024 WIDTH=1 shall be legal, with behaviour identical per bit to the wider case.

Reset
REQ-025 rst_n low shall immediately force master and q to INIT, and qn to ~INIT, without waiting for a clock edge.
REQ-026 While rst_n is low, both clock edges shall be ignored.
REQ-027 Reset asserted between a rising and a falling edge shall discard the pending master value; q shall stay INIT.
REQ-028 After rst_n deasserts, the first master update shall occur at the next rising edge and the first q change at the following falling edge.
REQ-029 err shall reset to 0 (when present).

Configuration
REQ-030 Macro MS_JK_ERR_EN shall select SR-violation detection.
REQ-031 With MS_JK_ERR_EN defined: err shall be set at the rising edge where mode=11 and, for any bit, en=1, j=1, k=1; err shall stay set until rst_n low; it shall not affect q.
REQ-032 Without MS_JK_ERR_EN: the err port and its logic shall be absent; q behaviour shall be identical to the build with the macro defined.

Verification
REQ-033 Reset: rst_n=0 mid-high-phase with INIT=8'hA5 -> q=8'hA5 and qn=8'h5A immediately; no change on clock edges until release.
REQ-034 JK mode, q=8'h00, j=8'hF0, k=8'h0F, en=8'hFF -> q=8'hF0 after the falling edge; next cycle j=k=8'hFF -> q=8'h0F, then 8'hF0, alternating each cycle.
REQ-035 Half-cycle timing: D mode, j changes 8'h00->8'h3C before a rising edge -> q still 8'h00 while clk is high, 8'h3C after the falling edge.
REQ-036 Enable mask: T mode, j=8'hFF, en=8'h01, q=8'h00 -> q=8'h01, 8'h00, 8'h01 over three cycles; bits 7..1 stay 0.
REQ-037 SR illegal: mode=11, j=k=8'h80, q=8'h80 -> q holds 8'h80; err=1 from that rising edge with MS_JK_ERR_EN defined, and stays 1 until reset.
REQ-038 Mode switch: master captured in JK toggle, mode changed to D before the falling edge -> q shows the toggled value, and D behaviour applies from the next cycle.

Source files
------------

// File: rtl/ms_jk_bank.sv
// ms_jk_bank: a bank of WIDTH independent master-slave flip-flops.
//
// Each bit has a master register that samples on the rising clock edge and
// a slave register (q) that copies the master on the falling edge. Because
// the slave only moves while clk is low, the master always computes from a
// q value that is stable across the whole high phase. This means a toggle
// flips q exactly once per cycle.
//
// Operating mode (common to all bits):
//   2'b00 JK : jk=00 hold, 01 clear, 10 set, 11 toggle
//   2'b01 D  : master <= j
//   2'b10 T  : master <= q ^ j
//   2'b11 SR : jk=00 hold, 10 set, 01 clear, 11 illegal -> hold
// A bit with en=0 holds, whatever the mode, j and k.
//
// Optional feature: define MS_JK_ERR_EN to add the sticky 'err' output.
// err is set at a rising edge when mode=SR and some enabled bit has j=k=1.
// It is cleared only by reset and never affects q.
//
// Parameters:
//   WIDTH : number of bits (1..64)
//   INIT  : value loaded into master and slave while reset is asserted
// Ports:
//   clk   : clock; master samples on rise, slave on fall
//   rst_n : asynchronous active-low reset
//   mode  : operating mode, see above
//   en    : per-bit enable
//   j     : J / D / T / S input per bit
//   k     : K / R input per bit (ignored in D and T modes)
//   q     : slave-stage output
//   qn    : ~q
//   err   : sticky SR-violation flag (MS_JK_ERR_EN builds only)
module ms_jk_bank #(
  parameter int unsigned          WIDTH = 8,
  parameter logic [WIDTH-1:0]     INIT  = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] en,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qn
`ifdef MS_JK_ERR_EN
  ,
  output logic             err
`endif
);

  localparam logic [1:0] MODE_JK = 2'b00;
  localparam logic [1:0] MODE_D  = 2'b01;
  localparam logic [1:0] MODE_T  = 2'b10;
  localparam logic [1:0] MODE_SR = 2'b11;

  logic [WIDTH-1:0] master;
  logic [WIDTH-1:0] func_next;
  logic [WIDTH-1:0] master_next;

  // Per-bit next-state function, written bitwise so that every bit depends
  // only on its own q, j and k.
  always_comb begin
    func_next = q;
    case (mode)
      // set where j=1,q=0; keep where k=0,q=1 -> hold/clear/set/toggle
      MODE_JK: func_next = (j & ~q) | (~k & q);
      MODE_D:  func_next = j;
      MODE_T:  func_next = q ^ j;
      // set on j&~k; keep q unless this is a clear (~j&k); j=k=1 keeps q
      MODE_SR: func_next = (j & ~k) | (q & ~(~j & k));
      default: func_next = q;
    endcase
    master_next = (en & func_next) | (~en & q);
  end

  // Master stage: rising edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      master <= INIT;
    end else begin
      master <= master_next;
    end
  end

  // Slave stage: falling edge. This is the only path that updates q. A
  // reset during the high phase reloads master, so the value it held
  // before the reset never reaches q.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= INIT;
    end else begin
      q <= master;
    end
  end

  assign qn = ~q;

`ifdef MS_JK_ERR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if ((mode == MODE_SR) && |(en & j & k)) begin
      err <= 1'b1;
    end
  end
`endif

endmodule
